// File: rtl/instr_fetch_unit_if.sv
// Purpose: fetch-stage bus bundle between the control/memory side and instr_fetch_unit.
// Signals:
//   i_stall, i_redirect, i_target : pipeline control into the fetch unit
//   i_imem_dout / o_imem_addr     : instruction memory read data / byte address
//   o_instr, o_pc, o_valid        : registered fetch result towards decode
//   o_trap, o_trap_addr           : sticky misaligned-redirect trap and offending target
//   o_fetch_cnt                   : count of delivered valid instructions
// Modports: slave = fetch unit, master = the environment driving it.
interface instr_fetch_unit_if #(
    parameter int unsigned DATA_LEN = 32
);
    logic                i_stall;
    logic                i_redirect;
    logic [DATA_LEN-1:0] i_target;
    logic [DATA_LEN-1:0] i_imem_dout;
    logic [DATA_LEN-1:0] o_imem_addr;
    logic [DATA_LEN-1:0] o_instr;
    logic [DATA_LEN-1:0] o_pc;
    logic                o_valid;
    logic                o_trap;
    logic [DATA_LEN-1:0] o_trap_addr;
    logic [31:0]         o_fetch_cnt;

    modport slave (
        input  i_stall, i_redirect, i_target, i_imem_dout,
        output o_imem_addr, o_instr, o_pc, o_valid, o_trap, o_trap_addr, o_fetch_cnt
    );

    modport master (
        output i_stall, i_redirect, i_target, i_imem_dout,
        input  o_imem_addr, o_instr, o_pc, o_valid, o_trap, o_trap_addr, o_fetch_cnt
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: program counter and fetch stage. Drives the instruction memory byte
// address from the PC register and registers the returned word with its PC.
// Handles redirects, stalls, sticky misaligned-target trap and a fetch counter.
// Ports:
//   i_clk  : rising-edge clock
//   i_rst  : asynchronous active-high reset
//   bus    : instr_fetch_unit_if.slave (control in, memory address/data, fetch outputs)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               i_clk,
    input  logic               i_rst,
    instr_fetch_unit_if.slave  bus
);
    localparam int unsigned DATA_LEN = 32;
    localparam int unsigned CNT_LEN  = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [DATA_LEN-1:0]  r_pc, w_pc_nxt;
    logic [DATA_LEN-1:0]  r_instr, w_instr_nxt;
    logic [DATA_LEN-1:0]  r_opc, w_opc_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_trap, w_trap_nxt;
    logic [DATA_LEN-1:0]  r_trap_addr, w_trap_addr_nxt;
    logic [CNT_LEN-1:0]   r_cnt, w_cnt_nxt;
    logic                 w_misaligned;

    assign w_misaligned = (bus.i_target[1:0] != 2'b00);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_BOOT;
        else       r_state <= w_state_nxt;
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc        <= RESET_PC;
            r_instr     <= NOP_INSTR;
            r_opc       <= '0;
            r_valid     <= 1'b0;
            r_trap      <= 1'b0;
            r_trap_addr <= '0;
            r_cnt       <= '0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_opc       <= w_opc_nxt;
            r_valid     <= w_valid_nxt;
            r_trap      <= w_trap_nxt;
            r_trap_addr <= w_trap_addr_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Next-state and next-register values; redirect beats stall, BOOT never delivers
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_opc_nxt       = r_opc;
        w_valid_nxt     = r_valid;
        w_trap_nxt      = r_trap;
        w_trap_addr_nxt = r_trap_addr;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            ST_BOOT, ST_RUN: begin
                w_state_nxt = ST_RUN;
                if (bus.i_redirect) begin
                    // in-flight fetch is squashed either way
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_INSTR;
                    if (w_misaligned) begin
                        w_state_nxt     = ST_TRAP;
                        w_trap_nxt      = 1'b1;
                        w_trap_addr_nxt = bus.i_target;
                    end else begin
                        w_pc_nxt  = bus.i_target;
                        w_opc_nxt = r_pc;
                    end
                end else if ((r_state == ST_RUN) && !bus.i_stall) begin
                    w_instr_nxt = bus.i_imem_dout;
                    w_opc_nxt   = r_pc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + DATA_LEN'(4);
                    w_cnt_nxt   = r_cnt + CNT_LEN'(1);
                end
            end
            ST_TRAP: begin
                w_valid_nxt = 1'b0;
                w_instr_nxt = NOP_INSTR;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign bus.o_imem_addr = r_pc;
    assign bus.o_instr     = r_instr;
    assign bus.o_pc        = r_opc;
    assign bus.o_valid     = r_valid;
    assign bus.o_trap      = r_trap;
    assign bus.o_trap_addr = r_trap_addr;
    assign bus.o_fetch_cnt = r_cnt;
endmodule
